// File: rtl/decode_stage.sv
// Decode stage: splits a fetched instruction into register addresses, immediate and
// control flags, holding the result in a backpressured output register.
module decode_stage #(
    parameter int unsigned ADDRESS_SIZE     = 32,
    parameter int unsigned REG_ADDRESS_SIZE = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_instruction,
    input  logic [ADDRESS_SIZE-1:0]     in_pc,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ADDRESS_SIZE-1:0]     out_pc,
    output logic [REG_ADDRESS_SIZE-1:0] addr_r1,
    output logic [REG_ADDRESS_SIZE-1:0] addr_r2,
    output logic [REG_ADDRESS_SIZE-1:0] addr_rd,
    output logic [ADDRESS_SIZE-1:0]     immediate,
    output logic [1:0]                  alu_op,
    output logic                        register_write,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic                        mem_byte,
    output logic                        branch,
    output logic                        jump,
    output logic                        illegal
);

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned IMM_W    = 15;

    typedef struct packed {
        logic [ADDRESS_SIZE-1:0]     pc;
        logic [REG_ADDRESS_SIZE-1:0] r1;
        logic [REG_ADDRESS_SIZE-1:0] r2;
        logic [REG_ADDRESS_SIZE-1:0] rd;
        logic [ADDRESS_SIZE-1:0]     imm;
        logic [1:0]                  alu_op;
        logic                        register_write;
        logic                        mem_read;
        logic                        mem_write;
        logic                        mem_byte;
        logic                        branch;
        logic                        jump;
        logic                        illegal;
    } decoded_t;

    logic [OPCODE_W-1:0]         opcode;
    logic [REG_ADDRESS_SIZE-1:0] field_a;
    logic [REG_ADDRESS_SIZE-1:0] field_b;
    logic [REG_ADDRESS_SIZE-1:0] field_c;
    logic [ADDRESS_SIZE-1:0]     imm_ext;
    decoded_t                    dec;
    decoded_t                    out_q;
    logic                        valid_q;
    logic                        hazard;

    assign opcode  = in_instruction[31:25];
    assign field_a = REG_ADDRESS_SIZE'(in_instruction[24:20]);
    assign field_b = REG_ADDRESS_SIZE'(in_instruction[19:15]);
    assign field_c = REG_ADDRESS_SIZE'(in_instruction[14:10]);
    assign imm_ext = {{(ADDRESS_SIZE-IMM_W){in_instruction[IMM_W-1]}}, in_instruction[IMM_W-1:0]};

    // Opcode decode; unused address fields and immediate stay zero
    always_comb begin
        dec    = '0;
        dec.pc = in_pc;
        case (opcode)
            7'h00, 7'h01, 7'h02: begin
                dec.rd             = field_a;
                dec.r1             = field_b;
                dec.r2             = field_c;
                dec.alu_op         = opcode[1:0];
                dec.register_write = 1'b1;
            end
            7'h10, 7'h11: begin
                dec.rd             = field_a;
                dec.r1             = field_b;
                dec.imm            = imm_ext;
                dec.mem_read       = 1'b1;
                dec.register_write = 1'b1;
                dec.mem_byte       = ~opcode[0];
            end
            7'h12, 7'h13: begin
                dec.r2        = field_a;
                dec.r1        = field_b;
                dec.imm       = imm_ext;
                dec.mem_write = 1'b1;
                dec.mem_byte  = ~opcode[0];
            end
            7'h30: begin
                dec.r1     = field_b;
                dec.r2     = field_a;
                dec.imm    = imm_ext;
                dec.alu_op = 2'd1;
                dec.branch = 1'b1;
            end
            7'h31: begin
                dec.r1   = field_b;
                dec.imm  = imm_ext;
                dec.jump = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        if (dec.rd == '0) begin
            dec.register_write = 1'b0;
        end
    end

    // Unused sources decode to r0 and addr_rd is nonzero here, so only real sources can match
    assign hazard = valid_q && out_q.mem_read && (out_q.rd != '0) &&
                    ((dec.r1 == out_q.rd) || (dec.r2 == out_q.rd));

    assign in_ready = !flush && !hazard && (!valid_q || out_ready);

    // Output register: flush beats load, load beats drain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            out_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            out_q   <= dec;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid      = valid_q;
    assign out_pc         = out_q.pc;
    assign addr_r1        = out_q.r1;
    assign addr_r2        = out_q.r2;
    assign addr_rd        = out_q.rd;
    assign immediate      = out_q.imm;
    assign alu_op         = out_q.alu_op;
    assign register_write = out_q.register_write;
    assign mem_read       = out_q.mem_read;
    assign mem_write      = out_q.mem_write;
    assign mem_byte       = out_q.mem_byte;
    assign branch         = out_q.branch;
    assign jump           = out_q.jump;
    assign illegal        = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode model feeding an expected-result queue, plus
// hazard, backpressure, flush and reset scenarios.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [1:0]  alu;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        mb;
        logic        br;
        logic        jp;
        logic        il;
    } dec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  addr_r1, addr_r2, addr_rd;
    logic [31:0] immediate;
    logic [1:0]  alu_op;
    logic        register_write, mem_read, mem_write, mem_byte, branch, jump, illegal;

    int   vectors = 0;
    int   miscompares = 0;
    dec_t q[$];

    decode_stage #(.ADDRESS_SIZE(32), .REG_ADDRESS_SIZE(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .addr_r1(addr_r1), .addr_r2(addr_r2), .addr_rd(addr_rd),
        .immediate(immediate), .alu_op(alu_op),
        .register_write(register_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte(mem_byte), .branch(branch), .jump(jump), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] a,
                                        input logic [4:0] b, input logic [14:0] low);
        return {op, a, b, low};
    endfunction

    // Reference decode written from the instruction set description
    function automatic dec_t model(input logic [31:0] ins, input logic [31:0] pc);
        dec_t        e;
        logic [6:0]  op;
        logic [4:0]  a, b, c;
        logic [31:0] sx;
        op = ins[31:25];
        a  = ins[24:20];
        b  = ins[19:15];
        c  = ins[14:10];
        sx = {{17{ins[14]}}, ins[14:0]};
        e  = '0;
        e.pc = pc;
        if (op == 7'h00 || op == 7'h01 || op == 7'h02) begin
            e.rd = a; e.r1 = b; e.r2 = c; e.alu = op[1:0]; e.rw = (a != 5'd0);
        end else if (op == 7'h10 || op == 7'h11) begin
            e.rd = a; e.r1 = b; e.imm = sx; e.mr = 1'b1; e.rw = (a != 5'd0);
            e.mb = (op == 7'h10);
        end else if (op == 7'h12 || op == 7'h13) begin
            e.r2 = a; e.r1 = b; e.imm = sx; e.mw = 1'b1; e.mb = (op == 7'h12);
        end else if (op == 7'h30) begin
            e.r1 = b; e.r2 = a; e.imm = sx; e.alu = 2'd1; e.br = 1'b1;
        end else if (op == 7'h31) begin
            e.r1 = b; e.imm = sx; e.jp = 1'b1;
        end else begin
            e.il = 1'b1;
        end
        return e;
    endfunction

    function automatic dec_t get_out();
        dec_t g;
        g.pc = out_pc; g.r1 = addr_r1; g.r2 = addr_r2; g.rd = addr_rd; g.imm = immediate;
        g.alu = alu_op; g.rw = register_write; g.mr = mem_read; g.mw = mem_write;
        g.mb = mem_byte; g.br = branch; g.jp = jump; g.il = illegal;
        return g;
    endfunction

    // Offer one instruction from a negedge and return at the negedge after it is taken
    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        bit ok = 1'b0;
        in_instruction = ins;
        in_pc          = pc;
        in_valid       = 1'b1;
        #1;
        for (int k = 0; k < 20; k++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: in_ready=%b required 1 for ins %h", in_ready, ins);
        end else begin
            q.push_back(model(ins, pc));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid: got %b required 0", out_valid);
        end
        vectors++;
        if (get_out() !== dec_t'(0)) begin
            miscompares++; $display("FAIL reset_fields: got %h required 0", get_out());
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_ldw();
        dec_t h;
        out_ready = 1'b1;
        send(32'h0030_8800, 32'h100);
        void'(q.pop_front());
        h = '0; h.pc = 32'h100; h.rd = 5'd3; h.r1 = 5'd1; h.r2 = 5'd2; h.rw = 1'b1;
        vectors++;
        if (out_valid !== 1'b1 || get_out() !== h) begin
            miscompares++;
            $display("FAIL add_decode: valid=%b got %h required %h", out_valid, get_out(), h);
        end
        send(32'h2251_7FFC, 32'h104);
        void'(q.pop_front());
        h = '0; h.pc = 32'h104; h.rd = 5'd5; h.r1 = 5'd2; h.imm = 32'hFFFF_FFFC;
        h.mr = 1'b1; h.rw = 1'b1;
        vectors++;
        if (out_valid !== 1'b1 || get_out() !== h) begin
            miscompares++;
            $display("FAIL ldw_decode: valid=%b got %h required %h", out_valid, get_out(), h);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] tbl [12];
        dec_t        exp;
        tbl[0]  = enc(7'h01, 5'd7,  5'd8,  15'(9  << 10));
        tbl[1]  = enc(7'h02, 5'd1,  5'd2,  15'(3  << 10));
        tbl[2]  = enc(7'h12, 5'd4,  5'd5,  15'h4000);
        tbl[3]  = enc(7'h13, 5'd6,  5'd7,  15'h0010);
        tbl[4]  = enc(7'h30, 5'd8,  5'd9,  15'h7FFF);
        tbl[5]  = enc(7'h31, 5'd10, 5'd11, 15'h3FFF);
        tbl[6]  = enc(7'h10, 5'd12, 5'd13, 15'h0001);
        tbl[7]  = enc(7'h00, 5'd14, 5'd15, 15'(16 << 10));
        tbl[8]  = enc(7'h7F, 5'd3,  5'd4,  15'h1234);
        tbl[9]  = enc(7'h03, 5'd1,  5'd2,  15'(3  << 10));
        tbl[10] = enc(7'h11, 5'd0,  5'd3,  15'h0004);
        tbl[11] = enc(7'h00, 5'd5,  5'd0,  15'h0000);
        out_ready = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) begin
                exp = q.pop_front();
                vectors++;
                if (out_valid !== 1'b1 || get_out() !== exp) begin
                    miscompares++;
                    $display("FAIL b2b_out[%0d]: valid=%b got %h required %h",
                             i - 1, out_valid, get_out(), exp);
                end
            end
            if (i < 12) begin
                in_instruction = tbl[i];
                in_pc          = 32'h200 + 32'(4 * i);
                in_valid       = 1'b1;
                #1;
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++; $display("FAIL b2b_ready[%0d]: got %b required 1", i, in_ready);
                end
                q.push_back(model(tbl[i], in_pc));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] ldw, add6;
        logic [31:0] cons [2];
        bit          stall [2];
        dec_t        exp;
        ldw  = 32'h2251_7FFC;
        add6 = 32'h0062_8400;
        out_ready = 1'b1;
        in_instruction = ldw; in_pc = 32'h300; in_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL lu_load_ready: got %b required 1", in_ready);
        end
        q.push_back(model(ldw, 32'h300));
        @(negedge clk);
        in_instruction = add6; in_pc = 32'h304;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL lu_stall: in_ready=%b required 0", in_ready);
        end
        exp = q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || get_out() !== exp) begin
            miscompares++;
            $display("FAIL lu_load_out: valid=%b got %h required %h", out_valid, get_out(), exp);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL lu_bubble: out_valid=%b required 0", out_valid);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL lu_release: in_ready=%b required 1", in_ready);
        end
        q.push_back(model(add6, 32'h304));
        @(negedge clk);
        in_valid = 1'b0;
        exp = q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || get_out() !== exp || addr_r1 !== 5'd5) begin
            miscompares++;
            $display("FAIL lu_consumer: valid=%b got %h required %h", out_valid, get_out(), exp);
        end
        @(negedge clk);
        // JMP ignores field A, STW reads it as r2
        cons[0] = enc(7'h31, 5'd5, 5'd3, 15'h0000); stall[0] = 1'b0;
        cons[1] = enc(7'h13, 5'd5, 5'd3, 15'h0008); stall[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_instruction = ldw; in_pc = 32'h320; in_valid = 1'b1;
            #1;
            q.push_back(model(ldw, 32'h320));
            @(negedge clk);
            in_instruction = cons[i]; in_pc = 32'h324;
            #1;
            vectors++;
            if (in_ready !== !stall[i]) begin
                miscompares++;
                $display("FAIL lu_source[%0d]: in_ready=%b required %b", i, in_ready, !stall[i]);
            end
            exp = q.pop_front();
            if (stall[i]) begin
                @(negedge clk);
                #1;
            end
            q.push_back(model(cons[i], 32'h324));
            @(negedge clk);
            in_valid = 1'b0;
            exp = q.pop_front();
            vectors++;
            if (out_valid !== 1'b1 || get_out() !== exp) begin
                miscompares++;
                $display("FAIL lu_cons_out[%0d]: valid=%b got %h required %h",
                         i, out_valid, get_out(), exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure_flush();
        dec_t exp, snap;
        out_ready = 1'b0;
        send(enc(7'h01, 5'd9, 5'd10, 15'(11 << 10)), 32'h400);
        exp  = q.pop_front();
        snap = get_out();
        vectors++;
        if (out_valid !== 1'b1 || snap !== exp) begin
            miscompares++;
            $display("FAIL bp_first: valid=%b got %h required %h", out_valid, snap, exp);
        end
        in_instruction = enc(7'h02, 5'd3, 5'd4, 15'(5 << 10));
        in_pc = 32'h404; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++; $display("FAIL bp_ready[%0d]: got %b required 0", c, in_ready);
            end
            vectors++;
            if (out_valid !== 1'b1 || get_out() !== snap) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: valid=%b got %h required %h",
                         c, out_valid, get_out(), snap);
            end
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL flush_ready: got %b required 0", in_ready);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL flush_kill: out_valid=%b required 0", out_valid);
        end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL flush_drop: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_illegal_r0();
        dec_t h, exp;
        out_ready = 1'b1;
        send(32'hFE00_0000, 32'h500);
        void'(q.pop_front());
        h = '0; h.pc = 32'h500; h.il = 1'b1;
        vectors++;
        if (out_valid !== 1'b1 || get_out() !== h) begin
            miscompares++;
            $display("FAIL illegal: valid=%b got %h required %h", out_valid, get_out(), h);
        end
        send(32'h0000_8800, 32'h504);
        exp = q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || get_out() !== exp || register_write !== 1'b0) begin
            miscompares++;
            $display("FAIL r0_write: valid=%b got %h required %h", out_valid, get_out(), exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        send(32'h0030_8800, 32'h600);
        q.delete();
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++; $display("FAIL rst_pre: out_valid=%b required 1", out_valid);
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || get_out() !== dec_t'(0)) begin
            miscompares++;
            $display("FAIL rst_async: valid=%b got %h required 0", out_valid, get_out());
        end
        #1 reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_instruction = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_add_ldw();
        test_back_to_back();
        test_load_use();
        test_backpressure_flush();
        test_illegal_r0();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
